// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared widths, beat count and assembler state encoding
package router_pkg;

  localparam int DATA_WIDTH        = 1024;
  localparam int ADDR_WIDTH        = 10;
  localparam int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH;
  localparam int AURORA_DATA_WIDTH = 64;

  // Beats needed to carry one packet, rounded up
  localparam int BEATS = (DATA_DFX_WIDTH + AURORA_DATA_WIDTH - 1) / AURORA_DATA_WIDTH;

  localparam int BEAT_CNT_W = 5;
  localparam int CNT_WIDTH  = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    DISCARD = 1'b1
  } asm_state_e;

endpackage

// File: rtl/router_sat_counter.sv
// rtl/router_sat_counter.sv - 16-bit increment-enable counter that holds at all-ones
module router_sat_counter
  import router_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // Count up on inc, sticking at the maximum value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/router_pkt_assembler.sv
// rtl/router_pkt_assembler.sv - gathers Aurora RX beats into packets for the packet FIFO
module router_pkt_assembler
  import router_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AURORA_DATA_WIDTH-1:0] rx_tdata,
  input  logic                         rx_tvalid,
  input  logic                         rx_tlast,
  input  logic                         full_pkt_fifo,
  output logic                         write_pkt_fifo,
  output logic [DATA_DFX_WIDTH-1:0]    pkt_fifo_din,
  output logic                         err_len,
  output logic                         drop_pkt,
  output logic [CNT_WIDTH-1:0]         rx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]         drop_cnt
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

  asm_state_e                  state_q, state_d;
  logic [BEAT_CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic                        complete_q, complete_d;
  logic                        err_q, err_d;
  logic                        store_en;
  logic [AURORA_DATA_WIDTH-1:0] beat_q [BEATS];
  logic [BEATS*AURORA_DATA_WIDTH-1:0] flat;
  logic                        unused_flat_hi;

  // State, beat index and the one-cycle completion/error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= COLLECT;
      beat_cnt_q <= '0;
      complete_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      complete_q <= complete_d;
      err_q      <= err_d;
    end
  end

  // Frame tracking: collect beats, flag short/long frames, swallow overlong tails
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    complete_d = 1'b0;
    err_d      = 1'b0;
    store_en   = 1'b0;
    case (state_q)
      COLLECT: begin
        if (rx_tvalid) begin
          store_en = 1'b1;
          if (rx_tlast) begin
            beat_cnt_d = '0;
            if (beat_cnt_q == LAST_BEAT) begin
              complete_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = DISCARD;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
          end
        end
      end
      DISCARD: begin
        if (rx_tvalid && rx_tlast) begin
          err_d      = 1'b1;
          beat_cnt_d = '0;
          state_d    = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Beat storage; a beat lands at the end of its cycle, so the register
  // contents stay stable during the write cycle even if beat 0 arrives then
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < BEATS; k++) begin
        beat_q[k] <= '0;
      end
    end else if (store_en) begin
      for (int k = 0; k < BEATS; k++) begin
        if (beat_cnt_q == BEAT_CNT_W'(k)) begin
          beat_q[k] <= rx_tdata;
        end
      end
    end
  end

  // Flatten beats LSB-first; the top of the last beat falls outside the packet
  always_comb begin
    flat = '0;
    for (int k = 0; k < BEATS; k++) begin
      flat[k*AURORA_DATA_WIDTH +: AURORA_DATA_WIDTH] = beat_q[k];
    end
  end

  assign pkt_fifo_din   = flat[DATA_DFX_WIDTH-1:0];
  assign unused_flat_hi = ^flat[BEATS*AURORA_DATA_WIDTH-1:DATA_DFX_WIDTH];

  assign write_pkt_fifo = complete_q & ~full_pkt_fifo;
  assign drop_pkt       = complete_q &  full_pkt_fifo;
  assign err_len        = err_q;

  router_sat_counter u_rx_pkt_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (write_pkt_fifo),
    .count (rx_pkt_cnt)
  );

  router_sat_counter u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_pkt | err_len),
    .count (drop_cnt)
  );

endmodule

// File: tb/tb_router_pkt_assembler.sv
// tb/tb_router_pkt_assembler.sv - directed table-driven bench for router_pkt_assembler
module tb_router_pkt_assembler;
  import router_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [AURORA_DATA_WIDTH-1:0] rx_tdata;
  logic                         rx_tvalid;
  logic                         rx_tlast;
  logic                         full_pkt_fifo;
  logic                         write_pkt_fifo;
  logic [DATA_DFX_WIDTH-1:0]    pkt_fifo_din;
  logic                         err_len;
  logic                         drop_pkt;
  logic [15:0]                  rx_pkt_cnt;
  logic [15:0]                  drop_cnt;

  always #5 clk = ~clk;

  router_pkt_assembler dut (
    .clk            (clk),
    .rst            (rst),
    .rx_tdata       (rx_tdata),
    .rx_tvalid      (rx_tvalid),
    .rx_tlast       (rx_tlast),
    .full_pkt_fifo  (full_pkt_fifo),
    .write_pkt_fifo (write_pkt_fifo),
    .pkt_fifo_din   (pkt_fifo_din),
    .err_len        (err_len),
    .drop_pkt       (drop_pkt),
    .rx_pkt_cnt     (rx_pkt_cnt),
    .drop_cnt       (drop_cnt)
  );

  int checks   = 0;
  int failures = 0;
  int wr_seen   = 0;
  int err_seen  = 0;
  int drop_seen = 0;

  always @(negedge clk) begin
    if (write_pkt_fifo) wr_seen++;
    if (err_len) err_seen++;
    if (drop_pkt) drop_seen++;
  end

  typedef struct {
    int seed;
    int len;
    bit full;
    int gap_after;
    bit exp_wr;
    bit exp_err;
    bit exp_drop;
    int exp_rx;
    int exp_dc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_pkt(input string name, input logic [DATA_DFX_WIDTH-1:0] act,
                         input logic [DATA_DFX_WIDTH-1:0] exp);
    logic [BEATS*64-1:0] a;
    logic [BEATS*64-1:0] e;
    checks++;
    if (act !== exp) begin
      failures++;
      a = '0;
      e = '0;
      a[DATA_DFX_WIDTH-1:0] = act;
      e[DATA_DFX_WIDTH-1:0] = exp;
      for (int k = 0; k < BEATS; k++) begin
        if (a[k*64 +: 64] !== e[k*64 +: 64]) begin
          $display("FAIL %s chunk=%0d actual=%0h expected=%0h", name, k, a[k*64 +: 64], e[k*64 +: 64]);
          break;
        end
      end
    end
  endtask

  function automatic logic [63:0] beat_val(input int seed, input int k);
    logic [31:0] v;
    v = 32'(seed * 256 + k);
    return {32'hA5A5_0000 + v, v};
  endfunction

  function automatic logic [DATA_DFX_WIDTH-1:0] exp_pkt(input int seed);
    logic [DATA_DFX_WIDTH-1:0] p;
    logic [63:0] b;
    p = '0;
    for (int k = 0; k < 16; k++) begin
      p[k*64 +: 64] = beat_val(seed, k);
    end
    b = beat_val(seed, 16);
    p[DATA_DFX_WIDTH-1:DATA_WIDTH] = b[9:0];
    return p;
  endfunction

  task automatic drive_beat(input logic [63:0] d, input logic last);
    rx_tdata  = d;
    rx_tvalid = 1'b1;
    rx_tlast  = last;
    @(posedge clk);
    #1;
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b1;
    rx_tdata  = {$urandom, $urandom};
    repeat (n) @(posedge clk);
    #1;
    rx_tlast  = 1'b0;
  endtask

  initial begin
    int exp_wr_total;
    int exp_err_total;
    int exp_drop_total;
    int wr0;
    logic [DATA_DFX_WIDTH-1:0] pkt0;

    //           seed len full gap wr err drop rx dc
    vecs[0]  = '{0,  17, 0, -1, 1, 0, 0, 1, 0};
    vecs[1]  = '{1,  17, 0,  5, 1, 0, 0, 2, 0};
    vecs[2]  = '{2,  17, 0, -1, 1, 0, 0, 3, 0};
    vecs[3]  = '{3,   6, 0, -1, 0, 1, 0, 3, 1};
    vecs[4]  = '{4,  17, 0, -1, 1, 0, 0, 4, 1};
    vecs[5]  = '{5,  20, 0, -1, 0, 1, 0, 4, 2};
    vecs[6]  = '{6,  17, 0, -1, 1, 0, 0, 5, 2};
    vecs[7]  = '{7,  17, 1, -1, 0, 0, 1, 5, 3};
    vecs[8]  = '{8,  17, 0, -1, 1, 0, 0, 6, 3};
    vecs[9]  = '{9,   1, 0, -1, 0, 1, 0, 6, 4};
    vecs[10] = '{10, 18, 0, -1, 0, 1, 0, 6, 5};
    vecs[11] = '{11, 17, 0, -1, 1, 0, 0, 7, 5};

    rst           = 1'b1;
    rx_tdata      = '0;
    rx_tvalid     = 1'b0;
    rx_tlast      = 1'b0;
    full_pkt_fifo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_write", 64'(write_pkt_fifo), 64'd0);
    chk("reset_err", 64'(err_len), 64'd0);
    chk("reset_drop", 64'(drop_pkt), 64'd0);
    chk("reset_rx_cnt", 64'(rx_pkt_cnt), 64'd0);
    chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
    chk_pkt("reset_din", pkt_fifo_din, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    exp_wr_total   = 0;
    exp_err_total  = 0;
    exp_drop_total = 0;
    wr_seen   = 0;
    err_seen  = 0;
    drop_seen = 0;

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < vecs[i].len; k++) begin
        drive_beat(beat_val(vecs[i].seed, k), (k == vecs[i].len - 1));
        if (k == 0) begin
          full_pkt_fifo = vecs[i].full;
          chk($sformatf("row%0d_prev_rx_cnt", i), 64'(rx_pkt_cnt),
              (i == 0) ? 64'd0 : 64'(vecs[i-1].exp_rx));
          chk($sformatf("row%0d_prev_drop_cnt", i), 64'(drop_cnt),
              (i == 0) ? 64'd0 : 64'(vecs[i-1].exp_dc));
        end
        if (k == vecs[i].gap_after) idle(2);
      end
      chk($sformatf("row%0d_write", i), 64'(write_pkt_fifo), 64'(vecs[i].exp_wr));
      chk($sformatf("row%0d_err", i), 64'(err_len), 64'(vecs[i].exp_err));
      chk($sformatf("row%0d_drop", i), 64'(drop_pkt), 64'(vecs[i].exp_drop));
      if (vecs[i].exp_wr || vecs[i].exp_drop) begin
        chk_pkt($sformatf("row%0d_data", i), pkt_fifo_din, exp_pkt(vecs[i].seed));
      end
      if (i == 0) begin
        pkt0 = pkt_fifo_din;
        chk("single_low_beat", pkt0[63:0], 64'hA5A5_0000_0000_0000);
        chk("single_addr", 64'(pkt0[DATA_DFX_WIDTH-1:DATA_WIDTH]), 64'h010);
      end
      exp_wr_total   += int'(vecs[i].exp_wr);
      exp_err_total  += int'(vecs[i].exp_err);
      exp_drop_total += int'(vecs[i].exp_drop);
    end

    idle(1);
    full_pkt_fifo = 1'b0;
    idle(1);
    chk("final_rx_cnt", 64'(rx_pkt_cnt), 64'(vecs[11].exp_rx));
    chk("final_drop_cnt", 64'(drop_cnt), 64'(vecs[11].exp_dc));
    chk("total_writes", 64'(wr_seen), 64'(exp_wr_total));
    chk("total_errs", 64'(err_seen), 64'(exp_err_total));
    chk("total_drops", 64'(drop_seen), 64'(exp_drop_total));

    // Reset in the middle of a packet, then a clean packet
    wr0 = wr_seen;
    for (int k = 0; k < 9; k++) begin
      drive_beat(beat_val(20, k), 1'b0);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_write", 64'(write_pkt_fifo), 64'd0);
    chk("midrst_err", 64'(err_len), 64'd0);
    chk("midrst_drop", 64'(drop_pkt), 64'd0);
    chk("midrst_rx_cnt", 64'(rx_pkt_cnt), 64'd0);
    chk("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk_pkt("midrst_din", pkt_fifo_din, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 17; k++) begin
      drive_beat(beat_val(21, k), (k == 16));
    end
    chk("postrst_write", 64'(write_pkt_fifo), 64'd1);
    chk_pkt("postrst_data", pkt_fifo_din, exp_pkt(21));
    idle(2);
    chk("postrst_one_write", 64'(wr_seen - wr0), 64'd1);
    chk("postrst_rx_cnt", 64'(rx_pkt_cnt), 64'd1);
    chk("postrst_drop_cnt", 64'(drop_cnt), 64'd0);

    // One-beat frames every cycle drive drop_cnt into saturation
    rx_tvalid = 1'b1;
    rx_tlast  = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("sat_drop_cnt", 64'(drop_cnt), 64'hFFFF);
    chk("sat_rx_cnt", 64'(rx_pkt_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_pkt_assembler.md
# router_pkt_assembler

Receive-side packet assembler between the Aurora RX user interface and the router's packet FIFO. Collects 64-bit Aurora beats into one DATA_DFX_WIDTH-bit packet (address + payload) and writes it to the packet FIFO. The FIFO is drained by the receive controller, which reads packets and starts the decoder. The block checks packet length, drops packets when the FIFO is full, and keeps saturating status counters.

## Interface
- DATA_WIDTH, 1024, payload width in bits
- ADDR_WIDTH, 10, destination address width
- DATA_DFX_WIDTH, DATA_WIDTH+ADDR_WIDTH, packet width written to FIFO
- AURORA_DATA_WIDTH, 64, Aurora RX beat width
- BEATS (localparam), ceil(DATA_DFX_WIDTH/AURORA_DATA_WIDTH) = 17, beats per packet
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- rx_tdata  in  AURORA_DATA_WIDTH  Aurora RX beat data
- rx_tvalid  in  1  beat valid; no backpressure exists
- rx_tlast  in  1  last beat of frame
- full_pkt_fifo  in  1  packet FIFO full
- write_pkt_fifo  out  1  FIFO write strobe, one cycle per packet
- pkt_fifo_din  out  DATA_DFX_WIDTH  assembled packet
- err_len  out  1  one-cycle pulse on a malformed frame
- drop_pkt  out  1  one-cycle pulse on a good packet lost to a full FIFO
- rx_pkt_cnt  out  16  packets written, saturating at 0xFFFF
- drop_cnt  out  16  drops plus length errors, saturating at 0xFFFF

## Operation
- Packet layout:
  - beat k fills bits [64k+63:64k] of the packet, LSB first.
  - Of beat 16, only bits [9:0] are kept; bits [63:10] are ignored.
  - pkt_fifo_din[DATA_WIDTH-1:0] is the payload.
  - pkt_fifo_din[DATA_DFX_WIDTH-1:DATA_WIDTH] is the address.
- beat_cnt: 5 bits, range 0..BEATS-1. It advances only on rx_tvalid.
- State COLLECT (reset state), on a beat with rx_tvalid:
  - Store the beat at index beat_cnt.
  - Beat with tlast and beat_cnt==BEATS-1: packet complete. beat_cnt←0; raise complete_q for the next cycle.
  - Beat with tlast and beat_cnt<BEATS-1 (early end): err_len pulse next cycle; beat_cnt←0; the partial packet is never written.
  - Beat without tlast and beat_cnt==BEATS-1 (overlong frame): beat_cnt←0; go to DISCARD.
  - Any other beat: beat_cnt←beat_cnt+1.
- State DISCARD:
  - Ignore all beats until one arrives with rx_tvalid&rx_tlast.
  - On that beat: err_len pulse next cycle; return to COLLECT with beat_cnt=0.
- Write cycle, when complete_q=1:
  - If !full_pkt_fifo: write_pkt_fifo=1 and rx_pkt_cnt increments.
  - Otherwise: write_pkt_fifo=0, drop_pkt=1 and drop_cnt increments.
- Each err_len pulse increments drop_cnt.
- Both counters hold at 0xFFFF.
- Assembly-register stability: a new packet's beat 0 may arrive in the write cycle. That beat is written at the end of the cycle, so pkt_fifo_din stays intact for the whole cycle in which write_pkt_fifo is high. No stall is needed.
- complete_q and an err_len event in the same cycle are impossible, because each needs a tlast beat.
- A drop and an err_len never occur in the same cycle either, so drop_cnt increments by at most 1 per cycle.

## Timing
- Reset (async assert; deassert sampled on clk):
  - State=COLLECT, beat_cnt=0, complete_q=0.
  - write_pkt_fifo=0, err_len=0, drop_pkt=0.
  - Both counters 0; pkt_fifo_din=0.
- Reset mid-packet discards the partial packet; nothing is written.
- Latency: write_pkt_fifo is high exactly 1 cycle after the clock edge that accepts the final beat.
- err_len is high 1 cycle after the offending tlast beat.
- full_pkt_fifo is sampled only in the write cycle.
- Back-to-back packets with continuous rx_tvalid are sustained: 17 beats give 1 write per 17 cycles.
- rx_tvalid=0 gaps inside a packet are allowed and do not alter beat_cnt.

## Structure
- Shared package router_pkg:
  - width constants DATA_WIDTH, ADDR_WIDTH, DATA_DFX_WIDTH, AURORA_DATA_WIDTH.
  - the BEATS computation.
  - the assembler state encoding: COLLECT=1'b0, DISCARD=1'b1.
- One natural sub-module, router_sat_counter: 16-bit, increment-enable, saturating, async active-high reset. It is instantiated twice, for rx_pkt_cnt and drop_cnt.
- Beat storage is a BEATS×64 register array, flattened and truncated to DATA_DFX_WIDTH.

## Test plan
- Single good packet:
  - Stimulus: 17 consecutive beats, beat k = {32'hA5A5_0000+k, 32'h0000_0000+k}; tlast on beat 16; FIFO not full.
  - Response: one write_pkt_fifo 1 cycle later; pkt_fifo_din[63:0]=64'hA5A5_0000_0000_0000; address = beat16[9:0]=10'h010; rx_pkt_cnt=1.
- Back-to-back with gaps:
  - Stimulus: 3 packets, rx_tvalid deasserted for 2 cycles inside packet 2, next packet's beat 0 arriving in each write cycle.
  - Response: 3 writes, each with correct data; rx_pkt_cnt=3.
- Short frame:
  - Stimulus: tlast on beat 5.
  - Response: err_len for 1 cycle; no write; drop_cnt=1; the following good packet is written correctly.
- Long frame:
  - Stimulus: 20 beats, tlast on beat 19.
  - Response: err_len 1 cycle after beat 19; no write; next packet is accepted.
- FIFO full:
  - Stimulus: full_pkt_fifo=1 in the write cycle.
  - Response: write_pkt_fifo=0; drop_pkt=1; drop_cnt increments; rx_pkt_cnt unchanged.
- Reset mid-packet:
  - Stimulus: assert rst after beat 8, then send a full good packet.
  - Response: all outputs 0 during reset; exactly one write, with the new packet's data.
